multi_issue_queue: RTL and testbench
====================================

# multi_issue_queue

Parametrised circular issue queue between decode and issue. Each cycle it accepts up to PUSH_W decoded instructions and presents up to POP_W of the oldest entries in program order. The issue stage retires any prefix of those entries. It generalises the fixed 4-in/2-out queue with configurable depth, port widths, a flush input and optional protocol-error detection.

## Interface
Parameters:
- DEPTH, 8: number of entries; power of two; must be ≥ PUSH_W and ≥ POP_W.
- PUSH_W, 4: push lanes per cycle.
- POP_W, 2: head lanes presented per cycle.
- ELEM_W, $bits(ISSUE_QUEUE_ELEMENT): entry width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all entries.
- in_data  in  PUSH_W×ELEM_W  push lanes; lane 0 is the oldest.
- in_count  in  $clog2(PUSH_W+1)  number of valid push lanes, 0..PUSH_W; lanes 0..in_count-1 are valid.
- space_left  out  $clog2(DEPTH+1)  free slots, DEPTH − count.
- out_data  out  POP_W×ELEM_W  head window; lane 0 is the oldest entry.
- out_valid  out  $clog2(POP_W+1)  valid head lanes, min(count, POP_W).
- pop_count  in  $clog2(POP_W+1)  number of head lanes consumed this cycle.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- proto_err  out  1  sticky protocol-error flag; see Configuration.

## Operation
- State:
  - storage array mem[DEPTH];
  - head and tail pointers, $clog2(DEPTH) bits each, wrapping modulo DEPTH;
  - count register, $clog2(DEPTH+1) bits.
- Accepted values:
  - push_acc = min(in_count, space_left);
  - pop_acc = min(pop_count, out_valid).
  - Excess requests are silently dropped.
- Push:
  - lane i is written to mem[(tail+i) mod DEPTH] for i < push_acc;
  - tail advances by push_acc.
- Pop: head advances by pop_acc. Popped storage is not cleared.
- Count update: count_next = count + push_acc − pop_acc.
- Head window: out_data lane j = mem[(head+j) mod DEPTH]. Lanes j ≥ out_valid are don't-care.
- Simultaneous push and pop:
  - space_left is computed from the pre-pop count; slots freed by a pop are not reusable in the same cycle;
  - pushes never overwrite unpopped entries.
- Flush priority: flush > push/pop. On flush, head = tail = count = 0 next cycle, and any push or pop in that cycle is ignored.
- Reset: head = tail = count = 0, proto_err = 0. Reset asserted mid-stream discards all contents, as flush does.

## Timing
- Push-to-visible latency: 1 cycle. An entry pushed in cycle N appears on out_data in cycle N+1. There is no same-cycle bypass.
- out_data, out_valid, count and space_left are combinational functions of registered state only. They have no combinational path from in_count, pop_count or flush.
- Reset values: count = 0, out_valid = 0, space_left = DEPTH, proto_err = 0. out_data is don't-care because out_valid = 0.
- Full queue (count = DEPTH): space_left = 0 and push_acc = 0, even if a pop occurs in the same cycle.
- Empty queue: out_valid = 0 and pop_acc = 0.
- Wrap-around: a multi-lane push or window read that crosses index DEPTH−1 continues at index 0.

## Configuration
- MIQ_PROTO_ERR_EN defined:
  - proto_err sets on the rising edge after any cycle (without flush) where in_count > space_left or pop_count > out_valid;
  - it stays set until rst; flush does not clear it.
- MIQ_PROTO_ERR_EN undefined:
  - proto_err is tied to 0 and no checking logic is built;
  - clamping behaviour is identical in both builds.

## Structure
- defines.svh holds:
  - ISSUE_QUEUE_ELEMENT;
  - count and pointer widths as localparam-derived typedefs;
  - the MIQ_PROTO_ERR_EN default (commented out).
- One sub-module, ring_window, does the modulo-DEPTH indexed read of N consecutive entries. It is instantiated for the head window and reused for write-index generation.

## Test plan
All scenarios use DEPTH=8, PUSH_W=4, POP_W=2.

- Reset, then idle: count=0, space_left=8, out_valid=0.
- Push 4 entries A..D, then 4 more E..H:
  - count=8, space_left=0;
  - a third push of 4 is dropped and count stays 8;
  - out_data = {A,B} with out_valid=2.
- Full queue, push 2 and pop 2 in the same cycle:
  - next cycle count=6 and the push is dropped;
  - the cycle after, a push of 2 is accepted and count=8.
- Wrap-around:
  - push 4, pop 2 each cycle for 6 cycles;
  - entries emerge strictly in push order across the index-7→0 boundary;
  - count returns to the expected value each cycle.
- Flush with in_count=3 and pop_count=2 asserted: next cycle count=0 and out_valid=0. A subsequent push of X appears at out_data lane 0 one cycle later.
- With MIQ_PROTO_ERR_EN, pop_count=2 while out_valid=1:
  - only 1 entry is popped;
  - proto_err=1 next cycle and stays 1 through a flush;
  - proto_err clears only on rst.

Source files
------------

// File: rtl/multi_issue_queue_pkg.sv
// rtl/multi_issue_queue_pkg.sv - shared element type and default width typedefs for the issue queue
// Uncomment to build sticky protocol-error detection: // `define MIQ_PROTO_ERR_EN
package multi_issue_queue_pkg;

  typedef struct packed {
    logic [7:0]  tag;
    logic [23:0] payload;
  } ISSUE_QUEUE_ELEMENT;

  localparam int MIQ_DEPTH = 8;
  localparam int MIQ_PTR_W = $clog2(MIQ_DEPTH);
  localparam int MIQ_CNT_W = $clog2(MIQ_DEPTH + 1);

  typedef logic [MIQ_PTR_W-1:0] miq_ptr_t;
  typedef logic [MIQ_CNT_W-1:0] miq_cnt_t;

endpackage

// File: rtl/multi_issue_queue_ring_window.sv
// rtl/multi_issue_queue_ring_window.sv - reads N consecutive ring entries starting at base, wrapping modulo DEPTH
module multi_issue_queue_ring_window #(
  parameter int DEPTH = 8,
  parameter int N     = 2,
  parameter int W     = 32
) (
  input  logic [$clog2(DEPTH)-1:0] base_i,
  input  logic [DEPTH*W-1:0]       ring_i,
  output logic [N*W-1:0]           win_o
);

  localparam int PTR_W = $clog2(DEPTH);

  for (genvar j = 0; j < N; j++) begin : g_lane
    logic [PTR_W-1:0] idx;
    // DEPTH is a power of two, so the pointer add wraps on its own
    assign idx = base_i + PTR_W'(j);
    assign win_o[j*W +: W] = ring_i[idx*W +: W];
  end

endmodule

// File: rtl/multi_issue_queue.sv
// rtl/multi_issue_queue.sv - circular multi-push/multi-pop issue queue; MIQ_PROTO_ERR_EN enables sticky proto_err
module multi_issue_queue
  import multi_issue_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PUSH_W = 4,
  parameter int POP_W  = 2,
  parameter int ELEM_W = $bits(ISSUE_QUEUE_ELEMENT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [PUSH_W*ELEM_W-1:0]     in_data,
  input  logic [$clog2(PUSH_W+1)-1:0]  in_count,
  output logic [$clog2(DEPTH+1)-1:0]   space_left,
  output logic [POP_W*ELEM_W-1:0]      out_data,
  output logic [$clog2(POP_W+1)-1:0]   out_valid,
  input  logic [$clog2(POP_W+1)-1:0]   pop_count,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(POP_W + 1);

  logic [ELEM_W-1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W-1:0]        push_acc, pop_acc;
  logic [DEPTH*ELEM_W-1:0] mem_flat;
  logic [DEPTH*PTR_W-1:0]  idx_table;
  logic [PUSH_W*PTR_W-1:0] wr_idx;

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign mem_flat[k*ELEM_W +: ELEM_W] = mem_q[k];
    assign idx_table[k*PTR_W +: PTR_W]  = PTR_W'(k);
  end

  multi_issue_queue_ring_window #(.DEPTH(DEPTH), .N(POP_W), .W(ELEM_W)) u_head_win (
    .base_i (head_q),
    .ring_i (mem_flat),
    .win_o  (out_data)
  );

  // Reading an identity table from tail yields the wrapped write slot of each push lane
  multi_issue_queue_ring_window #(.DEPTH(DEPTH), .N(PUSH_W), .W(PTR_W)) u_wr_idx (
    .base_i (tail_q),
    .ring_i (idx_table),
    .win_o  (wr_idx)
  );

  assign count      = count_q;
  assign space_left = CNT_W'(DEPTH) - count_q;
  assign out_valid  = (count_q < CNT_W'(POP_W)) ? OUT_W'(count_q) : OUT_W'(POP_W);

  always_comb begin
    push_acc = (CNT_W'(in_count) > space_left) ? space_left : CNT_W'(in_count);
    pop_acc  = (pop_count > out_valid) ? CNT_W'(out_valid) : CNT_W'(pop_count);
    head_d   = head_q + PTR_W'(pop_acc);
    tail_d   = tail_q + PTR_W'(push_acc);
    count_d  = count_q + push_acc - pop_acc;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_W; i++) begin
      if (!rst && !flush && (CNT_W'(i) < push_acc)) begin
        mem_q[wr_idx[i*PTR_W +: PTR_W]] <= in_data[i*ELEM_W +: ELEM_W];
      end
    end
  end

`ifdef MIQ_PROTO_ERR_EN
  logic proto_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err_q <= 1'b0;
    end else if (!flush && ((CNT_W'(in_count) > space_left) || (pop_count > out_valid))) begin
      proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_multi_issue_queue.sv
// tb/tb_multi_issue_queue.sv - directed self-checking bench for multi_issue_queue (DEPTH=8, PUSH_W=4, POP_W=2)
module tb_multi_issue_queue;

  localparam int DEPTH  = 8;
  localparam int PUSH_W = 4;
  localparam int POP_W  = 2;
  localparam int EW     = 32;

  logic                clk = 1'b0;
  logic                rst, flush;
  logic [PUSH_W*EW-1:0] in_data;
  logic [2:0]          in_count;
  logic [3:0]          space_left;
  logic [POP_W*EW-1:0] out_data;
  logic [1:0]          out_valid;
  logic [1:0]          pop_count;
  logic [3:0]          count;
  logic                proto_err;

  int tests = 0;
  int fails = 0;

  multi_issue_queue #(.DEPTH(DEPTH), .PUSH_W(PUSH_W), .POP_W(POP_W), .ELEM_W(EW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_data    (in_data),
    .in_count   (in_count),
    .space_left (space_left),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .pop_count  (pop_count),
    .count      (count),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] n, input logic [1:0] p,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    in_count  = n;
    pop_count = p;
    in_data   = {d, c, b, a};
  endtask

  logic [31:0] exp_q[$];
  int acc_tab[6] = '{4, 4, 2, 2, 2, 2};
  int pop_tab[6] = '{0, 2, 2, 2, 2, 2};
  int cnt_tab[6] = '{4, 6, 6, 6, 6, 6};
  logic exp_perr;

  initial begin
`ifdef MIQ_PROTO_ERR_EN
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    rst = 1'b1; flush = 1'b0;
    drive(3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_count", count, 4'd0);
    check("reset_space", space_left, 4'd8);
    check("reset_valid", out_valid, 2'd0);
    check("reset_perr", proto_err, 1'b0);

    // Over-pop: only the single entry leaves
    drive(3'd1, 2'd0, 32'h5A5A0001, 32'h0, 32'h0, 32'h0);
    tick();
    check("y_valid", out_valid, 2'd1);
    check("y_lane0", out_data[31:0], 32'h5A5A0001);
    drive(3'd0, 2'd2, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    check("overpop_count", count, 4'd0);
    check("overpop_perr", proto_err, exp_perr);
    drive(3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("perr_after_flush", proto_err, exp_perr);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("perr_after_rst", proto_err, 1'b0);

    // Fill to full, then an over-push is dropped
    drive(3'd4, 2'd0, 32'hA, 32'hB, 32'hC, 32'hD);
    tick();
    check("fill1_count", count, 4'd4);
    check("fill1_valid", out_valid, 2'd2);
    check("fill1_lanes", out_data, {32'hB, 32'hA});
    drive(3'd4, 2'd0, 32'hE, 32'hF, 32'h10, 32'h11);
    tick();
    check("fill2_count", count, 4'd8);
    check("fill2_space", space_left, 4'd0);
    drive(3'd4, 2'd0, 32'h20, 32'h21, 32'h22, 32'h23);
    tick();
    check("overfill_count", count, 4'd8);
    check("overfill_lanes", out_data, {32'hB, 32'hA});
    check("overfill_valid", out_valid, 2'd2);

    // Full: a same-cycle pop does not make room for the push
    drive(3'd2, 2'd2, 32'h30, 32'h31, 32'h0, 32'h0);
    tick();
    check("fullpp_count", count, 4'd6);
    check("fullpp_space", space_left, 4'd2);
    check("fullpp_lanes", out_data, {32'hD, 32'hC});
    drive(3'd2, 2'd0, 32'h30, 32'h31, 32'h0, 32'h0);
    tick();
    check("refill_count", count, 4'd8);
    check("refill_lanes", out_data, {32'hD, 32'hC});

    // Flush overrides simultaneous push and pop
    drive(3'd3, 2'd2, 32'h40, 32'h41, 32'h42, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_count", count, 4'd0);
    check("flush_valid", out_valid, 2'd0);
    drive(3'd1, 2'd0, 32'hCAFE0001, 32'h0, 32'h0, 32'h0);
    tick();
    check("postflush_lane0", out_data[31:0], 32'hCAFE0001);
    check("postflush_valid", out_valid, 2'd1);
    drive(3'd0, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    check("drain_count", count, 4'd0);

    // Wrap-around from head=tail=1: order must survive the 7->0 boundary
    for (int c = 0; c < 6; c++) begin
      logic [31:0] v[4];
      for (int l = 0; l < 4; l++) v[l] = 32'h100 + 32'(4 * c + l);
      drive(3'd4, 2'(pop_tab[c]), v[0], v[1], v[2], v[3]);
      tick();
      for (int k = 0; k < pop_tab[c]; k++) void'(exp_q.pop_front());
      for (int l = 0; l < acc_tab[c]; l++) exp_q.push_back(v[l]);
      check($sformatf("wrap%0d_count", c), count, 64'(cnt_tab[c]));
      check($sformatf("wrap%0d_lanes", c), out_data, {exp_q[1], exp_q[0]});
    end

    drive(3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_count", count, 4'd0);
    check("midrst_space", space_left, 4'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
